// File: rtl/conv_pkg.sv
// Shared types and helpers for the sequential convolver: FSM state encoding and
// accumulator sizing.
package conv_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StMac,
        StOut
    } conv_state_e;

    // Wide enough for N products of two DW-bit unsigned samples.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned n);
        return 2 * dw + $clog2(n);
    endfunction

endpackage

// File: rtl/seq_convolve_if.sv
// Sample-load and result-stream handshake bundle for seq_convolve.
interface seq_convolve_if #(
    parameter int unsigned DW = 4,
    parameter int unsigned N  = 8,
    parameter int unsigned OW = 4
);
    localparam int unsigned IW = $clog2(2 * N - 1);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_x;
    logic [DW-1:0] in_h;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic          busy;

    modport master (
        output in_valid, in_x, in_h, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_x, in_h, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );

endinterface

// File: rtl/conv_mac.sv
// Pipelined multiply-accumulate: product registered one cycle, then summed into
// an ACCW-bit accumulator. clr_i empties both the pipeline and the sum.
module conv_mac #(
    parameter int unsigned DW   = 4,
    parameter int unsigned ACCW = 11
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    output logic [ACCW-1:0] acc_o
);

    logic [2*DW-1:0] prod_q;
    logic            pvld_q;
    logic [ACCW-1:0] acc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            prod_q <= '0;
            pvld_q <= 1'b0;
            acc_q  <= '0;
        end else begin
            prod_q <= a_i * b_i;
            pvld_q <= en_i;
            if (pvld_q) begin
                acc_q <= acc_q + ACCW'(prod_q);
            end
        end
    end

    assign acc_o = acc_o_w();

    function automatic logic [ACCW-1:0] acc_o_w();
        return acc_q;
    endfunction

endmodule

// File: rtl/seq_convolve.sv
// Sequential full linear convolution of two N-sample vectors, one product per cycle.
// Define SEQ_CONVOLVE_SAT_EN to saturate out_data instead of truncating it.
module seq_convolve #(
    parameter int unsigned DW = 4,
    parameter int unsigned N  = 8,
    parameter int unsigned OW = 4
) (
    input logic           clk,
    input logic           rst,
    seq_convolve_if.slave bus
);
    import conv_pkg::*;

    localparam int unsigned ACCW = acc_width(DW, N);
    localparam int unsigned IW   = $clog2(2 * N - 1);
    localparam int unsigned NW   = $clog2(N);

    conv_state_e     state_q, state_d;
    logic [NW-1:0]   ld_q, ld_d;
    logic [IW-1:0]   k_q, k_d, k_nxt, j;
    logic [NW-1:0]   i_q, i_d;
    logic            drain_q, drain_d;
    logic [DW-1:0]   x_q [N];
    logic [DW-1:0]   h_q [N];
    logic            in_fire, out_fire, last_beat, last_term, last_k;
    logic            mac_clr, mac_en;
    logic [ACCW-1:0] acc;

    function automatic logic [NW-1:0] term_lo(input logic [IW-1:0] k);
        return (k >= IW'(N - 1)) ? NW'(k - IW'(N - 1)) : '0;
    endfunction

    function automatic logic [NW-1:0] term_hi(input logic [IW-1:0] k);
        return (k >= IW'(N - 1)) ? NW'(N - 1) : NW'(k);
    endfunction

    assign in_fire   = (state_q == StLoad) && bus.in_valid;
    assign out_fire  = (state_q == StOut) && bus.out_ready;
    assign last_beat = (ld_q == NW'(N - 1));
    assign last_term = (i_q == term_hi(k_q));
    assign last_k    = (k_q == IW'(2 * N - 2));
    assign k_nxt     = k_q + IW'(1);
    assign j         = k_q - IW'(i_q);

    always_ff @(posedge clk) begin
        if (rst) state_q <= StLoad;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StLoad:  if (in_fire && last_beat) state_d = StMac;
            StMac:   if (drain_q) state_d = StOut;
            StOut:   if (bus.out_ready) state_d = last_k ? StLoad : StMac;
            default: state_d = StLoad;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == StLoad);
        bus.out_valid = (state_q == StOut);
        bus.busy      = (state_q != StLoad);
        bus.out_last  = (state_q == StOut) && last_k;
        bus.out_idx   = k_q;
        mac_en        = (state_q == StMac) && !drain_q;
        mac_clr       = (in_fire && last_beat) || out_fire;
    end

    // One extra drain cycle in MAC lets the last registered product land in acc.
    always_comb begin
        ld_d    = ld_q;
        k_d     = k_q;
        i_d     = i_q;
        drain_d = drain_q;
        unique case (state_q)
            StLoad: if (in_fire) begin
                ld_d    = last_beat ? '0 : ld_q + NW'(1);
                k_d     = '0;
                i_d     = '0;
                drain_d = 1'b0;
            end
            StMac: begin
                if (drain_q)        drain_d = 1'b0;
                else if (last_term) drain_d = 1'b1;
                else                i_d     = i_q + NW'(1);
            end
            StOut: if (bus.out_ready) begin
                k_d = last_k ? '0 : k_nxt;
                i_d = last_k ? '0 : term_lo(k_nxt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q    <= '0;
            k_q     <= '0;
            i_q     <= '0;
            drain_q <= 1'b0;
        end else begin
            ld_q    <= ld_d;
            k_q     <= k_d;
            i_q     <= i_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire && !rst) begin
            x_q[ld_q] <= bus.in_x;
            h_q[ld_q] <= bus.in_h;
        end
    end

    conv_mac #(
        .DW   (DW),
        .ACCW (ACCW)
    ) u_mac (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (x_q[i_q]),
        .b_i   (h_q[j[NW-1:0]]),
        .acc_o (acc)
    );

    logic unused_j_hi;
    assign unused_j_hi = ^j[IW-1:NW];

`ifdef SEQ_CONVOLVE_SAT_EN
    localparam logic [ACCW-1:0] SatMax = ACCW'((2 ** OW) - 1);
    assign bus.out_data = (acc > SatMax) ? {OW{1'b1}} : acc[OW-1:0];
`else
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc[ACCW-1:OW];
    assign bus.out_data  = acc[OW-1:0];
`endif

endmodule

// File: tb/tb_seq_convolve.sv
// Directed self-checking bench for seq_convolve at DW=4, N=8, OW=4.
module tb_seq_convolve;

    localparam int unsigned DW = 4;
    localparam int unsigned N  = 8;
    localparam int unsigned OW = 4;
    localparam int unsigned NK = 2 * N - 1;

    typedef logic [DW-1:0] vec_t [N];
    typedef logic [OW-1:0] res_t [NK];

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_convolve_if #(.DW(DW), .N(N), .OW(OW)) bus ();

    seq_convolve #(.DW(DW), .N(N), .OW(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t ones    = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
    vec_t fifteen = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    vec_t unit    = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    vec_t ramp    = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    vec_t mix_x   = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd3};
    vec_t mix_h   = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd2};

    res_t exp_tri  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                       4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
    res_t exp_ramp = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                       4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    res_t exp_mix  = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7,
                       4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd6};
`ifdef SEQ_CONVOLVE_SAT_EN
    res_t exp_f15  = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15,
                       4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
`else
    // 225*T mod 16 == T, so truncation reproduces the triangle.
    res_t exp_f15  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                       4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
`endif

    task automatic load_frame(input vec_t xs, input vec_t hs, input bit gap, input bit hold);
        for (int b = 0; b < int'(N); b++) begin
            if (gap && b > 0) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_x     = 4'(b + 9);
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_x     = xs[b];
            bus.in_h     = hs[b];
        end
        @(negedge clk);
        bus.in_valid  = hold;
        bus.in_x      = 4'($urandom);
        bus.in_h      = 4'($urandom);
        bus.out_ready = 1'b0;
    endtask

    task automatic expect_frame(input res_t exp, input int stall_idx, input int stall_len,
                                input bit noise, input string name);
        int k       = 0;
        int stalled = 0;
        for (int cyc = 0; cyc < 600 && k < int'(NK); cyc++) begin
            @(negedge clk);
            if (noise && k < int'(NK)) begin
                bus.in_valid = 1'b1;
                bus.in_x     = 4'($urandom);
                bus.in_h     = 4'($urandom);
            end
            if (bus.out_valid) begin
                checks++;
                if (bus.out_data !== exp[k] || bus.out_idx !== 4'(k) ||
                    bus.out_last !== (k == int'(NK) - 1)) begin
                    errors++;
                    $display("FAIL %s k=%0d: got data=%0d idx=%0d last=%b, want data=%0d idx=%0d last=%b",
                             name, k, bus.out_data, bus.out_idx, bus.out_last,
                             exp[k], k, (k == int'(NK) - 1));
                end
                if (k == stall_idx && stalled < stall_len) begin
                    bus.out_ready = 1'b0;
                    stalled++;
                end else begin
                    bus.out_ready = 1'b1;
                    k++;
                    if (k == int'(NK)) bus.in_valid = 1'b0;
                end
            end else begin
                bus.out_ready = 1'b1;
            end
        end
        checks++;
        if (k != int'(NK)) begin
            errors++;
            $display("FAIL %s timeout: got %0d outputs, want %0d", name, k, NK);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s back_to_load: got ready=%b busy=%b ovalid=%b, want 1 0 0",
                     name, bus.in_ready, bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_data !== 4'd0 || bus.out_idx !== 4'd0 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset: got rdy=%b ov=%b busy=%b data=%0d idx=%0d last=%b, want 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_data, bus.out_idx,
                     bus.out_last);
        end
        rst = 1'b0;
    endtask

    task automatic test_ones();
        load_frame(ones, ones, 1'b0, 1'b0);
        expect_frame(exp_tri, -1, 0, 1'b0, "ones");
    endtask

    task automatic test_fifteen_gaps();
        load_frame(fifteen, fifteen, 1'b1, 1'b0);
        expect_frame(exp_f15, -1, 0, 1'b0, "fifteen");
    endtask

    task automatic test_impulse_latency();
        load_frame(unit, ramp, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency_c1: got ov=%b busy=%b rdy=%b, want 0 1 0",
                     bus.out_valid, bus.busy, bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_c2: got out_valid=%b, want 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_c3: got out_valid=%b, want 1", bus.out_valid);
        end
        expect_frame(exp_ramp, -1, 0, 1'b0, "impulse");
    endtask

    task automatic test_stall();
        load_frame(ones, ones, 1'b0, 1'b0);
        expect_frame(exp_tri, 3, 5, 1'b0, "stall");
    endtask

    task automatic test_mixed();
        load_frame(mix_x, mix_h, 1'b0, 1'b0);
        expect_frame(exp_mix, -1, 0, 1'b0, "mixed");
    endtask

    task automatic test_reset_mid_mac();
        bit found = 1'b0;
        load_frame(ones, ones, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_idx == 4'd5) found = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (!found || bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mac_k6: got found=%b busy=%b ov=%b, want 1 1 0",
                     found, bus.busy, bus.out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_idx !== 4'd0 || bus.out_data !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%b ov=%b busy=%b idx=%0d data=%0d, want 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_idx, bus.out_data);
        end
        load_frame(unit, ramp, 1'b0, 1'b0);
        expect_frame(exp_ramp, -1, 0, 1'b0, "after_reset");
    endtask

    task automatic test_busy_ignore();
        load_frame(ones, ones, 1'b0, 1'b1);
        expect_frame(exp_tri, -1, 0, 1'b1, "busy_ignore");
        load_frame(mix_x, mix_h, 1'b0, 1'b0);
        expect_frame(exp_mix, -1, 0, 1'b0, "after_busy");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_x      = '0;
        bus.in_h      = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        test_reset();
        test_ones();
        test_fifteen_gaps();
        test_impulse_latency();
        test_stall();
        test_mixed();
        test_reset_mid_mac();
        test_busy_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_convolve.md
SEQ_CONVOLVE -- requirements
Module: seq_convolve

Interface
REQ-001 SHALL have parameter DW, default 4, unsigned sample width of x and h.
REQ-002 SHALL have parameter N, default 8, vector length (N >= 2).
REQ-003 SHALL have parameter OW, default 4, output sample width.
REQ-004 SHALL derive localparams ACCW = 2*DW + $clog2(N) (accumulator) and IW = $clog2(2*N-1) (output index).
REQ-005 SHALL have one clock; reset is synchronous and active-high: clk, input, 1, rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  x/h sample pair valid.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 in_x  input  DW  sample x[i]; in_h  input  DW  sample h[i], same beat.
REQ-010 out_valid  output  1  out_data/out_idx/out_last valid.
REQ-011 out_ready  input  1  consumer accepts output.
REQ-012 out_data  output  OW  y[k]; out_idx  output  IW  k; out_last  output  1  high when k = 2N-2.
REQ-013 busy  output  1  high in any state other than LOAD.

Function
REQ-014 SHALL compute full linear convolution y[k] = sum over i of x[i]*h[k-i], k = 0..2N-2, for valid i with 0 <= i, k-i <= N-1, all unsigned.
REQ-015 SHALL implement states LOAD, MAC, OUT.
REQ-016 LOAD: in_ready=1; each in_valid&in_ready beat stores pair at index 0..N-1 in arrival order; gaps in in_valid allowed.
REQ-017 After N-th accepted beat SHALL enter MAC next cycle with k=0, accumulator cleared, in_ready=0.
REQ-018 MAC: one product per cycle, i from max(0,k-N+1) to min(k,N-1); after last term enter OUT.
REQ-019 OUT: out_valid=1; out_data, out_idx, out_last SHALL hold stable until out_valid&out_ready.
REQ-020 On OUT handshake with k<2N-2: clear accumulator, k+1, return to MAC; with k=2N-2: return to LOAD, in_ready=1 next cycle.
REQ-021 Output k SHALL appear exactly T_k+1 cycles after entering MAC for k, T_k = min(k,N-1)-max(0,k-N+1)+1 terms; k=0 out_valid 2 cycles after last input beat.
REQ-022 Accumulator SHALL be ACCW bits and never overflow.
REQ-023 Default output rule: out_data = acc[OW-1:0] (truncate).
REQ-024 in_valid while busy SHALL be ignored (not stored, no effect).

Reset
REQ-025 rst SHALL, at any state incl. mid-MAC/OUT, force LOAD, load index 0, k 0, accumulator 0 on next edge.
REQ-026 Reset values: in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0; stored samples need not be cleared.

Configuration
REQ-027 Macro SEQ_CONVOLVE_SAT_EN defined: out_data = 2^OW-1 when acc > 2^OW-1, else acc[OW-1:0].
REQ-028 Macro undefined: truncation per REQ-023; no saturation logic synthesised.

Structure
REQ-029 Package conv_pkg SHALL hold the state enum (LOAD, MAC, OUT) and an accumulator-width function used for ACCW.
REQ-030 Sub-module conv_mac SHALL hold multiply-accumulate (DW x DW into ACCW, clear and enable inputs); FSM, sample storage and indexing stay in seq_convolve.

Verification (defaults DW=4, N=8, OW=4)
REQ-031 x=h=all 1 -> out_data 1,2,3,4,5,6,7,8,7,...,1 for idx 0..14, out_last only at idx 14.
REQ-032 x=h=all 15 -> idx 0 = 225 truncated 1 / saturated 15; idx 7 = 1800 truncated 8 / saturated 15.
REQ-033 x=[1,0,...,0], h=[1..8] -> out_data 1..8 at idx 0..7, 0 at idx 8..14; first out_valid 2 cycles after 8th beat.
REQ-034 x=h=all 1, out_ready low 5 cycles at idx 3 -> out_data 4, idx 3 held stable; sequence continues unchanged.
REQ-035 rst pulsed in MAC at k=6 -> next cycle in_ready=1, out_valid=0, busy=0; fresh 8-beat load yields correct full sequence.
REQ-036 in_valid held high during busy with changing data -> outputs match first load only.
